// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans a 4x4 active-high matrix keypad with a one-hot column drive.
// Rows are synchronized, then a press is debounced, locked to one key, and
// decoded to a hex code. A one-cycle valid strobe and a two-deep digit
// history are presented to the display multiplexer.
module keypad_scan_ctrl #(
  parameter int TICK_DIV       = 1200,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] row_async,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int TK_W = $clog2(TICK_DIV);
  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_TICKS);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);

  // Three state bits leave spare encodings; any of them recovers to SCAN.
  localparam logic [2:0] ST_SCAN     = 3'd0;
  localparam logic [2:0] ST_PRESS_DB = 3'd1;
  localparam logic [2:0] ST_HELD     = 3'd2;
  localparam logic [2:0] ST_REL_DB   = 3'd3;

  // Lowest set row wins when several rows are active in one column.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rows[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Column index to one-hot column drive.
  function automatic logic [3:0] col_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0001;
    endcase
    return oh;
  endfunction

  // Keypad legend: {row, col} to hex code.
  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] cidx);
    logic [3:0] code;
    case ({row, cidx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  logic [3:0]      r_row_meta;
  logic [3:0]      r_row_s;
  logic [TK_W-1:0] r_tick_cnt;
  logic [2:0]      r_state;
  logic [1:0]      r_col_idx;
  logic [3:0]      r_col;
  logic [1:0]      r_lock_row;
  logic [1:0]      r_lock_col;
  logic [DB_W-1:0] r_db_cnt;
  logic [3:0]      r_key_code;
  logic            r_key_valid;
  logic            r_key_held;
  logic [3:0]      r_digit_new;
  logic [3:0]      r_digit_old;

  logic            w_tick;
  logic            w_row_hit;
  logic [1:0]      w_col_idx_inc;
  logic [DB_W-1:0] w_db_inc;
  logic [2:0]      w_state_nxt;
  logic [1:0]      w_col_idx_nxt;
  logic [3:0]      w_col_nxt;
  logic [1:0]      w_lock_row_nxt;
  logic [1:0]      w_lock_col_nxt;
  logic [DB_W-1:0] w_db_cnt_nxt;
  logic            w_accept;
  logic            w_release;
  logic [3:0]      w_code;

  assign w_tick        = (r_tick_cnt == TK_LAST);
  assign w_row_hit     = r_row_s[r_lock_row];
  assign w_col_idx_inc = r_col_idx + 2'd1;
  assign w_db_inc      = r_db_cnt + DB_ONE;
  assign w_code        = decode_key(w_lock_row_nxt, w_lock_col_nxt);

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_row_meta <= 4'b0000;
      r_row_s    <= 4'b0000;
    end else begin
      r_row_meta <= row_async;
      r_row_s    <= r_row_meta;
    end
  end

  // Free-running scan tick divider; also sets the column settle time.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TK_W'(1);
    end
  end

  // Next-state logic: scan, press debounce, hold and release debounce.
  always_comb begin
    w_state_nxt    = r_state;
    w_col_idx_nxt  = r_col_idx;
    w_col_nxt      = r_col;
    w_lock_row_nxt = r_lock_row;
    w_lock_col_nxt = r_lock_col;
    w_db_cnt_nxt   = r_db_cnt;
    w_accept       = 1'b0;
    w_release      = 1'b0;
    if (r_state > ST_REL_DB) begin
      w_state_nxt   = ST_SCAN;
      w_col_idx_nxt = 2'd0;
      w_col_nxt     = 4'b0001;
      w_db_cnt_nxt  = DB_ZERO;
    end else if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (r_row_s != 4'b0000) begin
            w_lock_row_nxt = lowest_row(r_row_s);
            w_lock_col_nxt = r_col_idx;
            w_db_cnt_nxt   = DB_ONE;
            if (DB_ONE == DB_MAX) begin
              w_accept    = 1'b1;
              w_state_nxt = ST_HELD;
            end else begin
              w_state_nxt = ST_PRESS_DB;
            end
          end else begin
            w_col_idx_nxt = w_col_idx_inc;
            w_col_nxt     = col_onehot(w_col_idx_inc);
          end
        end
        ST_PRESS_DB: begin
          if (w_row_hit) begin
            w_db_cnt_nxt = w_db_inc;
            if (w_db_inc == DB_MAX) begin
              w_accept    = 1'b1;
              w_state_nxt = ST_HELD;
            end else begin
              w_state_nxt = ST_PRESS_DB;
            end
          end else begin
            w_col_idx_nxt = w_col_idx_inc;
            w_col_nxt     = col_onehot(w_col_idx_inc);
            w_state_nxt   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (!w_row_hit) begin
            w_db_cnt_nxt = DB_ONE;
            if (DB_ONE == DB_MAX) begin
              w_release     = 1'b1;
              w_col_idx_nxt = w_col_idx_inc;
              w_col_nxt     = col_onehot(w_col_idx_inc);
              w_state_nxt   = ST_SCAN;
            end else begin
              w_state_nxt = ST_REL_DB;
            end
          end else begin
            w_state_nxt = ST_HELD;
          end
        end
        ST_REL_DB: begin
          if (!w_row_hit) begin
            w_db_cnt_nxt = w_db_inc;
            if (w_db_inc == DB_MAX) begin
              w_release     = 1'b1;
              w_col_idx_nxt = w_col_idx_inc;
              w_col_nxt     = col_onehot(w_col_idx_inc);
              w_state_nxt   = ST_SCAN;
            end else begin
              w_state_nxt = ST_REL_DB;
            end
          end else begin
            // Release bounce: back to holding, no new strobe.
            w_state_nxt = ST_HELD;
          end
        end
        default: begin
          w_state_nxt   = ST_SCAN;
          w_col_idx_nxt = 2'd0;
          w_col_nxt     = 4'b0001;
          w_db_cnt_nxt  = DB_ZERO;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Scan state, column drive, lock fields and debounce count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_SCAN;
      r_col_idx  <= 2'd0;
      r_col      <= 4'b0001;
      r_lock_row <= 2'd0;
      r_lock_col <= 2'd0;
      r_db_cnt   <= DB_ZERO;
    end else begin
      r_state    <= w_state_nxt;
      r_col_idx  <= w_col_idx_nxt;
      r_col      <= w_col_nxt;
      r_lock_row <= w_lock_row_nxt;
      r_lock_col <= w_lock_col_nxt;
      r_db_cnt   <= w_db_cnt_nxt;
    end
  end

  // Key outputs: strobe, held flag and digit history update on acceptance.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_digit_new <= 4'h0;
      r_digit_old <= 4'h0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code  <= w_code;
        r_key_held  <= 1'b1;
        r_digit_new <= w_code;
        r_digit_old <= r_digit_new;
      end else if (w_release) begin
        r_key_held  <= 1'b0;
      end else begin
        r_key_held  <= r_key_held;
      end
    end
  end

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign digit_new = r_digit_new;
  assign digit_old = r_digit_old;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: a simulated keypad matrix driven by the
// column outputs, directed scenarios plus random presses, every cycle
// compared with a tick-level behavioural model of the scanner.
module tb_keypad_scan_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;

  logic        clk;
  logic        nrst;
  logic [3:0]  row_async;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [3:0]  digit_new;
  logic [3:0]  digit_old;

  logic [15:0] pressed;   // bit r*4+c = key at row r, column c is down
  int          n_total;
  int          n_bad;
  int          pulses;
  int          base;

  keypad_scan_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DEB)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .row_async (row_async),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digit_new (digit_new),
    .digit_old (digit_old)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: a row reads high when a pressed key sits in the driven column.
  always_comb begin
    row_async = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && col[c]) row_async[r] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int MD_IDLE = 0, MD_CONFIRM = 1, MD_DOWN = 2, MD_CONFIRM_UP = 3;
  logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};
  int         m_mode, m_ci, m_row, m_lcol, m_agree, m_edges;
  logic [3:0] m_h1, m_h2;
  logic [3:0] m_code, m_new, m_old;
  logic       m_valid, m_held;

  function automatic int lowest_bit(input logic [3:0] v);
    int b;
    b = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) b = i;
    return b;
  endfunction

  task automatic model_reset();
    m_mode = MD_IDLE; m_ci = 0; m_row = 0; m_lcol = 0; m_agree = 0; m_edges = 0;
    m_h1 = 4'h0; m_h2 = 4'h0;
    m_code = 4'h0; m_new = 4'h0; m_old = 4'h0; m_valid = 1'b0; m_held = 1'b0;
  endtask

  task automatic model_accept();
    m_code  = code_tab[m_row*4 + m_lcol];
    m_old   = m_new;
    m_new   = m_code;
    m_valid = 1'b1;
    m_held  = 1'b1;
    m_mode  = MD_DOWN;
  endtask

  task automatic model_release();
    m_held = 1'b0;
    m_ci   = (m_ci + 1) % 4;
    m_mode = MD_IDLE;
  endtask

  task automatic model_step();
    logic [3:0] rs;
    rs = m_h2; m_h2 = m_h1; m_h1 = row_async;
    m_valid = 1'b0;
    m_edges++;
    if (m_edges % TICK_DIV == 0) begin
      if (m_mode == MD_IDLE) begin
        if (rs != 4'h0) begin
          m_row = lowest_bit(rs); m_lcol = m_ci; m_agree = 1;
          if (m_agree >= DEB) model_accept(); else m_mode = MD_CONFIRM;
        end else m_ci = (m_ci + 1) % 4;
      end else if (m_mode == MD_CONFIRM) begin
        if (rs[m_row]) begin
          m_agree++;
          if (m_agree >= DEB) model_accept();
        end else begin
          m_ci = (m_ci + 1) % 4; m_mode = MD_IDLE;
        end
      end else if (m_mode == MD_DOWN) begin
        if (!rs[m_row]) begin
          m_agree = 1;
          if (m_agree >= DEB) model_release(); else m_mode = MD_CONFIRM_UP;
        end
      end else begin
        if (!rs[m_row]) begin
          m_agree++;
          if (m_agree >= DEB) model_release();
        end else m_mode = MD_DOWN;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) model_reset(); else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (nrst) begin
        chk("col",       col,       32'(4'b0001 << m_ci));
        chk("key_code",  key_code,  m_code);
        chk("key_valid", key_valid, m_valid);
        chk("key_held",  key_held,  m_held);
        chk("digit_new", digit_new, m_new);
        chk("digit_old", digit_old, m_old);
        if (key_valid) pulses++;
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * TICK_DIV) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col"},  col,       4'b0001);
    chk({tag, "_code"}, key_code,  4'h0);
    chk({tag, "_vld"},  key_valid, 1'b0);
    chk({tag, "_held"}, key_held,  1'b0);
    chk({tag, "_new"},  digit_new, 4'h0);
    chk({tag, "_old"},  digit_old, 4'h0);
  endtask

  initial begin
    n_total = 0; n_bad = 0; pulses = 0;
    pressed = 16'h0;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    nrst = 1'b1;

    // Idle scan: no keys, no strobes.
    wait_ticks(9);
    chk("idle_pulses", pulses, 0);

    // Key 5 held, then released.
    base = pulses;
    pressed = 16'h0; pressed[5] = 1'b1;
    wait_ticks(20);
    chk("k5_pulses", pulses - base, 1);
    chk("k5_code", key_code, 4'h5);
    chk("k5_new", digit_new, 4'h5);
    chk("k5_old", digit_old, 4'h0);
    chk("k5_held", key_held, 1'b1);
    chk("k5_col", col, 4'b0010);
    pressed = 16'h0;
    wait_ticks(6);
    chk("k5_rel_held", key_held, 1'b0);
    chk("k5_rel_pulses", pulses - base, 1);

    // Press bounce: one tick down, one tick up, never accepted.
    base = pulses;
    for (int i = 0; i < 8; i++) begin
      pressed[5] = ~pressed[5];
      wait_ticks(1);
    end
    pressed = 16'h0;
    wait_ticks(4);
    chk("bounce_pulses", pulses - base, 0);

    // Release bounce inside HELD.
    base = pulses;
    pressed[5] = 1'b1;
    wait_ticks(12);
    pressed[5] = 1'b0;
    wait_ticks(1);
    pressed[5] = 1'b1;
    wait_ticks(6);
    chk("relb_held", key_held, 1'b1);
    chk("relb_pulses", pulses - base, 1);
    pressed = 16'h0;
    wait_ticks(6);

    // A, plus D in the same column while A is held, then 0.
    base = pulses;
    pressed[3] = 1'b1;
    wait_ticks(10);
    pressed[15] = 1'b1;
    wait_ticks(4);
    pressed[15] = 1'b0;
    wait_ticks(2);
    chk("a_code", key_code, 4'hA);
    pressed = 16'h0;
    wait_ticks(6);
    pressed[13] = 1'b1;
    wait_ticks(10);
    chk("a0_new", digit_new, 4'h0);
    chk("a0_old", digit_old, 4'hA);
    chk("a0_pulses", pulses - base, 2);
    pressed = 16'h0;
    wait_ticks(6);

    // Reset in the middle of HELD, key stays down.
    pressed[5] = 1'b1;
    wait_ticks(12);
    chk("pre_rst_held", key_held, 1'b1);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    base = pulses;
    wait_ticks(20);
    chk("rerst_pulses", pulses - base, 1);
    chk("rerst_code", key_code, 4'h5);
    chk("rerst_old", digit_old, 4'h0);
    chk("rerst_held", key_held, 1'b1);
    pressed = 16'h0;
    wait_ticks(6);

    // Random presses, holds, bounces and chords.
    for (int i = 0; i < 40; i++) begin
      pressed = 16'h0;
      pressed[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      wait_ticks($urandom_range(1, 8));
      pressed = 16'h0;
      wait_ticks($urandom_range(1, 8));
    end
    wait_ticks(8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
